// File: rtl/uart_alu_frame_if.sv
// FIFO-side handshake bundle for uart_alu_frame: RX FIFO head/pop and TX FIFO push.
// master = the command stage, slave = the FIFO pair.
interface uart_alu_frame_if #(
  parameter int NB_DATA = 8
) ();
  logic               i_rx_empty;
  logic [NB_DATA-1:0] i_rx_data;
  logic               o_rx_rd;
  logic               i_tx_full;
  logic               o_tx_wr;
  logic [NB_DATA-1:0] o_tx_data;

  modport master (
    input  i_rx_empty, i_rx_data, i_tx_full,
    output o_rx_rd, o_tx_wr, o_tx_data
  );

  modport slave (
    output i_rx_empty, i_rx_data, i_tx_full,
    input  o_rx_rd, o_tx_wr, o_tx_data
  );
endinterface

// File: rtl/uart_alu_frame.sv
// UART command/response stage: pops {A, B, OP} from the RX FIFO and pushes one ALU result byte.
// `define UART_ALU_CHECKSUM_EN adds a 4th checksum byte CK = A^B^OP; a mismatch answers 8'hEE.
module uart_alu_frame #(
  parameter int NB_DATA     = 8,
  parameter int NB_CODE     = 6,
  parameter int NB_TIMEOUT  = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  uart_alu_frame_if.master fifo,
  output logic             o_busy,
  output logic             o_frame_err
);

`ifdef UART_ALU_CHECKSUM_EN
  // The whole OP byte is kept so it can take part in the checksum.
  localparam int NB_OP = NB_DATA;
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, GET_CK, EXEC, SEND} state_t;
`else
  localparam int NB_OP = NB_CODE;
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;
`endif

  localparam int                    TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [NB_TIMEOUT-1:0] TO_LAST   = NB_TIMEOUT'(TO_LAST_I);

  localparam logic [NB_CODE-1:0] OP_ADD = NB_CODE'('h20);
  localparam logic [NB_CODE-1:0] OP_SUB = NB_CODE'('h22);
  localparam logic [NB_CODE-1:0] OP_AND = NB_CODE'('h24);
  localparam logic [NB_CODE-1:0] OP_OR  = NB_CODE'('h25);
  localparam logic [NB_CODE-1:0] OP_XOR = NB_CODE'('h26);
  localparam logic [NB_CODE-1:0] OP_NOR = NB_CODE'('h27);
  localparam logic [NB_CODE-1:0] OP_SRL = NB_CODE'('h02);
  localparam logic [NB_CODE-1:0] OP_SRA = NB_CODE'('h03);

  state_t                state_q, state_d;
  logic [NB_DATA-1:0]    a_q, b_q, result_q;
  logic [NB_OP-1:0]      op_q;
  logic [NB_TIMEOUT-1:0] to_cnt_q;
  logic                  err_q;
  logic                  rx_rd, tx_wr, timeout_hit, ck_bad;
  logic                  in_wait, to_expired;

  function automatic logic [NB_DATA-1:0] alu(input logic [NB_DATA-1:0] x,
                                             input logic [NB_DATA-1:0] y,
                                             input logic [NB_CODE-1:0] code);
    logic [NB_DATA-1:0] r;
    // Shift counts are the full unsigned B, so B >= NB_DATA flushes to 0 or sign fill.
    case (code)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_SRL:  r = x >> y;
      OP_SRA:  r = $unsigned($signed(x) >>> y);
      default: r = '1;
    endcase
    return r;
  endfunction

  // Only the mid-frame wait states can time out; GET_A waits forever.
`ifdef UART_ALU_CHECKSUM_EN
  assign in_wait = (state_q == GET_B) || (state_q == GET_OP) || (state_q == GET_CK);
`else
  assign in_wait = (state_q == GET_B) || (state_q == GET_OP);
`endif
  assign to_expired = (TIMEOUT_CYC != 0) && (to_cnt_q == TO_LAST);

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch; the FIFO strobes are Mealy on the empty/full flags.
  always_comb begin
    state_d     = state_q;
    rx_rd       = 1'b0;
    tx_wr       = 1'b0;
    timeout_hit = 1'b0;
    ck_bad      = 1'b0;
    case (state_q)
      GET_A: if (!fifo.i_rx_empty) begin
        rx_rd   = 1'b1;
        state_d = GET_B;
      end
      GET_B: if (!fifo.i_rx_empty) begin
        rx_rd   = 1'b1;
        state_d = GET_OP;
      end
      GET_OP: if (!fifo.i_rx_empty) begin
        rx_rd   = 1'b1;
`ifdef UART_ALU_CHECKSUM_EN
        state_d = GET_CK;
`else
        state_d = EXEC;
`endif
      end
`ifdef UART_ALU_CHECKSUM_EN
      GET_CK: if (!fifo.i_rx_empty) begin
        rx_rd = 1'b1;
        if (fifo.i_rx_data != (a_q ^ b_q ^ op_q)) begin
          ck_bad  = 1'b1;
          state_d = SEND;
        end else begin
          state_d = EXEC;
        end
      end
`endif
      EXEC: state_d = SEND;
      SEND: if (!fifo.i_tx_full) begin
        tx_wr   = 1'b1;
        state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase
    if (in_wait && fifo.i_rx_empty && to_expired) begin
      timeout_hit = 1'b1;
      state_d     = GET_A;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= GET_A;
    else          state_q <= state_d;
  end

  // Saturating idle counter; restarts on each pop and whenever the frame restarts.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      to_cnt_q <= '0;
    end else if (rx_rd || (state_d == GET_A)) begin
      to_cnt_q <= '0;
    end else if (in_wait && fifo.i_rx_empty && (to_cnt_q != '1)) begin
      to_cnt_q <= to_cnt_q + NB_TIMEOUT'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit | ck_bad;
      if (rx_rd) begin
        case (state_q)
          GET_A:   a_q  <= fifo.i_rx_data;
          GET_B:   b_q  <= fifo.i_rx_data;
          GET_OP:  op_q <= fifo.i_rx_data[NB_OP-1:0];
          default: ;
        endcase
      end
      if (state_q == EXEC) result_q <= alu(a_q, b_q, op_q[NB_CODE-1:0]);
      if (ck_bad)          result_q <= NB_DATA'(8'hEE);
    end
  end

  // GET_A's pop is Mealy on rx_empty, so it is masked while reset is held.
  assign fifo.o_rx_rd   = rx_rd && i_reset;
  assign fifo.o_tx_wr   = tx_wr;
  assign fifo.o_tx_data = result_q;
  assign o_busy         = (state_q != GET_A);
  assign o_frame_err    = err_q;

endmodule

// File: tb/tb_uart_alu_frame.sv
// Self-checking bench for uart_alu_frame: FIFO emulation, transaction-level reference model
// checked every cycle, directed scenarios plus randomized byte streams with backpressure.
module tb_uart_alu_frame;
  localparam int TO = 16;
`ifdef UART_ALU_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, frame_err;

  uart_alu_frame_if #(.NB_DATA(8)) fifo ();

  uart_alu_frame #(
    .NB_DATA(8), .NB_CODE(6), .NB_TIMEOUT(20), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .fifo(fifo), .o_busy(busy), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int push_cnt = 0;
  int err_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  logic pop_req = 1'b0;
  logic [7:0] rx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the arithmetic definitions.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op);
    int ia, ib, sa;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    case (op[5:0])
      6'h20:   return 8'((ia + ib) % 256);
      6'h22:   return 8'((ia - ib + 256) % 256);
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return (ib >= 8) ? 8'h00 : 8'(ia / (1 << ib));
      6'h03:   return (ib >= 8) ? {8{a[7]}} : 8'(sa >>> ib);
      default: return 8'hFF;
    endcase
  endfunction

  // Model state: bytes of the frame in progress, pending result and its age.
  logic [7:0] frame[$];
  int   idle = 0;
  int   age = 0;
  bit   pend = 0;
  bit   pend_bad = 0;
  bit   err_next = 0;
  logic [7:0] exp_res = 8'h00;

  always @(negedge clk) begin
    bit e_rd, e_wr, e_busy;
    if (!rst_n) begin
      check("rst_rx_rd", fifo.o_rx_rd, 0);
      check("rst_tx_wr", fifo.o_tx_wr, 0);
      check("rst_tx_data", fifo.o_tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      frame.delete();
      idle = 0;
      pend = 0;
      err_next = 0;
      pop_req = 1'b0;
    end else begin
      e_rd   = !pend && !fifo.i_rx_empty;
      e_wr   = pend && (age >= (pend_bad ? 0 : 1)) && !fifo.i_tx_full;
      e_busy = (frame.size() != 0) || pend;
      check("rx_rd", fifo.o_rx_rd, e_rd);
      check("tx_wr", fifo.o_tx_wr, e_wr);
      check("busy", busy, e_busy);
      check("frame_err", frame_err, err_next);
      check("one_strobe", fifo.o_rx_rd && fifo.o_tx_wr, 0);
      if (e_wr) check("tx_data", fifo.o_tx_data, exp_res);
      if (fifo.o_tx_wr) begin
        push_cnt++;
        last_tx = fifo.o_tx_data;
      end
      if (frame_err) err_cnt++;
      pop_req = fifo.o_rx_rd;
      err_next = 0;
      if (pend) begin
        if (e_wr) pend = 0;
        else      age++;
      end
      if (e_rd) begin
        frame.push_back(fifo.i_rx_data);
        idle = 0;
        if (frame.size() == FRAME_LEN) begin
          pend     = 1;
          age      = 0;
          pend_bad = 0;
          exp_res  = ref_alu(frame[0], frame[1], frame[2]);
`ifdef UART_ALU_CHECKSUM_EN
          if (frame[3] != (frame[0] ^ frame[1] ^ frame[2])) begin
            pend_bad = 1;
            exp_res  = 8'hEE;
            err_next = 1;
          end
`endif
          frame.delete();
        end
      end else if (frame.size() != 0) begin
        idle++;
        if (idle == TO) begin
          frame.delete();
          idle = 0;
          err_next = 1;
        end
      end
    end
  end

  function automatic void drive_rx();
    fifo.i_rx_empty = (rx_q.size() == 0);
    fifo.i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endfunction

  // One clock: the FIFO pops what the DUT strobed, then inputs settle before the next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (pop_req && rx_q.size() != 0) void'(rx_q.pop_front());
    drive_rx();
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    rx_q.push_back(b);
    drive_rx();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    put(a);
    put(b);
    put(op);
`ifdef UART_ALU_CHECKSUM_EN
    put(a ^ b ^ op);
`endif
  endtask

  task automatic wait_push(input int n, input string name);
    int k = 0;
    while (push_cnt < n && k < 100) begin
      cycle();
      k++;
    end
    check({name, "_push_seen"}, (push_cnt >= n), 1);
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] ops[9] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03, 8'h3F};
    if ($urandom_range(0, 1) == 0) return ops[$urandom_range(0, 8)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e, gap;
    logic [7:0] t2[4][4] = '{'{8'h03, 8'h05, 8'h22, 8'hFE},
                             '{8'hF0, 8'h04, 8'h03, 8'hFF},
                             '{8'h0F, 8'hF0, 8'h27, 8'h00},
                             '{8'h12, 8'h34, 8'h3F, 8'hFF}};
    fifo.i_tx_full = 1'b0;
    drive_rx();

    // Hand-computed values pinning the reference ALU.
    check("model_add", ref_alu(8'h05, 8'h03, 8'h20), 8'h08);
    check("model_sub", ref_alu(8'h03, 8'h05, 8'h22), 8'hFE);
    check("model_sra", ref_alu(8'hF0, 8'h04, 8'h03), 8'hFF);
    check("model_nor", ref_alu(8'h0F, 8'hF0, 8'h27), 8'h00);
    check("model_srl", ref_alu(8'hF0, 8'h04, 8'h02), 8'h0F);
    check("model_sra_big", ref_alu(8'h80, 8'h09, 8'h03), 8'hFF);
    check("model_bad_op", ref_alu(8'h12, 8'h34, 8'h3F), 8'hFF);

    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Basic ADD frame.
    n = push_cnt;
    send_frame(8'h05, 8'h03, 8'h20);
    wait_push(n + 1, "t1");
    check("t1_data", last_tx, 8'h08);

    // SUB / SRA / NOR / unknown opcode.
    for (int i = 0; i < 4; i++) begin
      n = push_cnt;
      send_frame(t2[i][0], t2[i][1], t2[i][2]);
      wait_push(n + 1, "t2");
      check("t2_data", last_tx, t2[i][3]);
    end

    // Backpressure: no pushes and no further pops while TX is full.
    fifo.i_tx_full = 1'b1;
    n = push_cnt;
    send_frame(8'h05, 8'h03, 8'h22);
    send_frame(8'h04, 8'h04, 8'h20);
    repeat (12) cycle();
    check("t3_no_push", push_cnt, n);
    check("t3_rx_held", rx_q.size(), FRAME_LEN);
    fifo.i_tx_full = 1'b0;
    wait_push(n + 1, "t3a");
    check("t3a_data", last_tx, 8'h02);
    wait_push(n + 2, "t3b");
    check("t3b_data", last_tx, 8'h08);
    check("t3_single_push", push_cnt, n + 2);

    // Inter-byte timeout drops the partial frame.
    n = push_cnt;
    e = err_cnt;
    put(8'h05);
    repeat (30) cycle();
    check("t4_err_pulse", err_cnt, e + 1);
    check("t4_no_push", push_cnt, n);
    check("t4_idle", busy, 0);
    send_frame(8'h0F, 8'hF0, 8'h25);
    wait_push(n + 1, "t4");
    check("t4_data", last_tx, 8'hFF);

    // Asynchronous reset in GET_OP; queued bytes form a fresh frame.
    n = push_cnt;
    put(8'h05);
    put(8'h03);
    repeat (4) cycle();
    check("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rx_rd", fifo.o_rx_rd, 0);
    check("t5_tx_wr", fifo.o_tx_wr, 0);
    check("t5_tx_data", fifo.o_tx_data, 0);
    check("t5_busy", busy, 0);
    check("t5_frame_err", frame_err, 0);
    send_frame(8'h07, 8'h02, 8'h20);
    cycle();
    #1;
    check("t5_rx_rd_in_reset", fifo.o_rx_rd, 0);
    rst_n = 1'b1;
    wait_push(n + 1, "t5");
    check("t5_data", last_tx, 8'h09);

`ifdef UART_ALU_CHECKSUM_EN
    n = push_cnt;
    e = err_cnt;
    put(8'h05); put(8'h03); put(8'h20); put(8'h26);
    wait_push(n + 1, "t6_good");
    check("t6_good_data", last_tx, 8'h08);
    put(8'h05); put(8'h03); put(8'h20); put(8'h00);
    wait_push(n + 2, "t6_bad");
    check("t6_bad_data", last_tx, 8'hEE);
    check("t6_bad_err", err_cnt, e + 1);
`endif

    // Randomized byte stream with random TX backpressure and occasional long gaps.
    gap = 0;
    for (int i = 0; i < 1500; i++) begin
      cycle();
      fifo.i_tx_full = ($urandom_range(0, 3) == 0);
      if (gap > 0) begin
        gap--;
      end else if ($urandom_range(0, 99) < 3) begin
        gap = $urandom_range(18, 25);
      end else if ($urandom_range(0, 1) == 1 && rx_q.size() < 4) begin
        put(pick_byte());
      end
    end

    fifo.i_tx_full = 1'b0;
    repeat (60) cycle();
    check("drain_rx_empty", rx_q.size(), 0);
    check("drain_idle", busy, 0);
    check("random_pushes", (push_cnt > 20), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
